// File: rtl/pw_auth_lockout_ctrl.sv
// pw_auth_lockout_ctrl
//   Password authentication controller with timed lockout, lockout escalation,
//   automatic release and in-session password change.
//
//   Each rising edge of enter_btn submits password_in against the stored password.
//   A match opens an unlocked window. A mismatch flashes led_fail. MAX_ATTEMPTS
//   consecutive mismatches lock the controller out. Each lockout is twice as long
//   as the one before it, up to MAX_ESCALATE doublings. A successful unlock
//   resets the escalation.
//
// Ports
//   clk            system clock, rising edge
//   rst            asynchronous active-high reset
//   enter_btn      submit attempt (level input, rising edge acts)
//   change_btn     store password_in as new password while unlocked (rising edge acts)
//   password_in    entered / new password
//   led_success    high for the whole unlocked window
//   led_fail       high PULSE_CYCLES per rejected attempt
//   led_locked     high for the whole lockout
//   pw_changed     one-cycle pulse when the stored password is updated
//   attempts_left  MAX_ATTEMPTS minus consecutive failures so far
module pw_auth_lockout_ctrl #(
    parameter int unsigned         PW_WIDTH      = 16,
    parameter logic [PW_WIDTH-1:0] DEFAULT_PW    = 16'h1234,
    parameter int unsigned         MAX_ATTEMPTS  = 3,
    parameter int unsigned         PULSE_CYCLES  = 4,
    parameter int unsigned         UNLOCK_CYCLES = 16,
    parameter int unsigned         LOCK_CYCLES   = 20,
    parameter int unsigned         MAX_ESCALATE  = 3
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                enter_btn,
    input  logic                                change_btn,
    input  logic [PW_WIDTH-1:0]                 password_in,
    output logic                                led_success,
    output logic                                led_fail,
    output logic                                led_locked,
    output logic                                pw_changed,
    output logic [$clog2(MAX_ATTEMPTS+1)-1:0]   attempts_left
);

    localparam int unsigned AW       = $clog2(MAX_ATTEMPTS + 1);
    localparam int unsigned MAX_LOCK = LOCK_CYCLES << MAX_ESCALATE;
    // The timer has to hold the longest of the three window lengths.
    localparam int unsigned MAX_A    = (UNLOCK_CYCLES > PULSE_CYCLES) ? UNLOCK_CYCLES
                                                                      : PULSE_CYCLES;
    localparam int unsigned MAX_T    = (MAX_LOCK > MAX_A) ? MAX_LOCK : MAX_A;
    localparam int unsigned TW       = $clog2(MAX_T + 1);
    localparam int unsigned LW       = (MAX_ESCALATE > 0) ? $clog2(MAX_ESCALATE + 1) : 1;

    typedef enum logic [1:0] {StIdle, StUnlocked, StFail, StLocked} state_e;

    state_e              state;
    logic [PW_WIDTH-1:0] stored_pw;
    logic [AW-1:0]       fail_cnt;
    logic [LW-1:0]       lock_level;
    logic [TW-1:0]       timer;
    logic                enter_q;
    logic                change_q;

    logic                enter_rise;
    logic                change_rise;
    logic                pw_match;
    logic                last_try;
    logic                timer_done;
    logic [TW-1:0]       lock_len;

    assign enter_rise  = enter_btn & ~enter_q;
    assign change_rise = change_btn & ~change_q;
    assign pw_match    = (password_in == stored_pw);
    assign last_try    = (32'(fail_cnt) + 32'd1) >= MAX_ATTEMPTS;
    // A state is left on the cycle its timer reads 1, so an N-cycle load keeps
    // the matching LED high for exactly N cycles.
    assign timer_done  = (timer == TW'(1));
    // lock_level saturates at MAX_ESCALATE, so the shift never exceeds it.
    assign lock_len    = TW'(LOCK_CYCLES) << lock_level;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= StIdle;
            stored_pw     <= DEFAULT_PW;
            fail_cnt      <= '0;
            lock_level    <= '0;
            timer         <= '0;
            enter_q       <= 1'b0;
            change_q      <= 1'b0;
            led_success   <= 1'b0;
            led_fail      <= 1'b0;
            led_locked    <= 1'b0;
            pw_changed    <= 1'b0;
            attempts_left <= AW'(MAX_ATTEMPTS);
        end else begin
            // Edge history advances in every state so a button held through
            // a busy state cannot fire when that state ends.
            enter_q    <= enter_btn;
            change_q   <= change_btn;
            pw_changed <= 1'b0;

            unique case (state)
                StIdle: begin
                    if (enter_rise) begin
                        if (pw_match) begin
                            state         <= StUnlocked;
                            timer         <= TW'(UNLOCK_CYCLES);
                            fail_cnt      <= '0;
                            lock_level    <= '0;
                            led_success   <= 1'b1;
                            attempts_left <= AW'(MAX_ATTEMPTS);
                        end else if (!last_try) begin
                            state         <= StFail;
                            timer         <= TW'(PULSE_CYCLES);
                            fail_cnt      <= fail_cnt + AW'(1);
                            led_fail      <= 1'b1;
                            attempts_left <= AW'(MAX_ATTEMPTS - 32'(fail_cnt) - 32'd1);
                        end else begin
                            state         <= StLocked;
                            timer         <= lock_len;
                            fail_cnt      <= '0;
                            led_locked    <= 1'b1;
                            attempts_left <= AW'(MAX_ATTEMPTS);
                            if (32'(lock_level) < MAX_ESCALATE) begin
                                lock_level <= lock_level + LW'(1);
                            end
                        end
                    end
                end

                StUnlocked: begin
                    // A password change takes priority over a simultaneous enter.
                    if (change_rise) begin
                        stored_pw   <= password_in;
                        pw_changed  <= 1'b1;
                        state       <= StIdle;
                        led_success <= 1'b0;
                    end else if (enter_rise || timer_done) begin
                        state       <= StIdle;
                        led_success <= 1'b0;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end

                StFail: begin
                    if (timer_done) begin
                        state    <= StIdle;
                        led_fail <= 1'b0;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end

                StLocked: begin
                    if (timer_done) begin
                        state      <= StIdle;
                        led_locked <= 1'b0;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end

                default: begin
                    state       <= StIdle;
                    led_success <= 1'b0;
                    led_fail    <= 1'b0;
                    led_locked  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pw_auth_lockout_ctrl.sv
// Self-checking bench for pw_auth_lockout_ctrl.
// A window-based reference model (absolute end cycles for each indicator) is
// compared against the DUT every cycle, and directed scenarios add literal
// expectations on pulse lengths, counters and async reset.
module tb_pw_auth_lockout_ctrl;

    localparam int unsigned PW_WIDTH      = 16;
    localparam logic [15:0] DEFAULT_PW    = 16'h1234;
    localparam int unsigned MAX_ATTEMPTS  = 3;
    localparam int unsigned PULSE_CYCLES  = 4;
    localparam int unsigned UNLOCK_CYCLES = 16;
    localparam int unsigned LOCK_CYCLES   = 20;
    localparam int unsigned MAX_ESCALATE  = 3;

    logic        clk;
    logic        rst;
    logic        enter_btn;
    logic        change_btn;
    logic [15:0] password_in;
    logic        led_success;
    logic        led_fail;
    logic        led_locked;
    logic        pw_changed;
    logic [1:0]  attempts_left;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    pw_auth_lockout_ctrl #(
        .PW_WIDTH      (PW_WIDTH),
        .DEFAULT_PW    (DEFAULT_PW),
        .MAX_ATTEMPTS  (MAX_ATTEMPTS),
        .PULSE_CYCLES  (PULSE_CYCLES),
        .UNLOCK_CYCLES (UNLOCK_CYCLES),
        .LOCK_CYCLES   (LOCK_CYCLES),
        .MAX_ESCALATE  (MAX_ESCALATE)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enter_btn     (enter_btn),
        .change_btn    (change_btn),
        .password_in   (password_in),
        .led_success   (led_success),
        .led_fail      (led_fail),
        .led_locked    (led_locked),
        .pw_changed    (pw_changed),
        .attempts_left (attempts_left)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Each indicator is described by the last edge index at which its mode is
    // still in force; the indicator is high after edge j while j < end.
    int          m_cyc;
    int          m_succ_end;
    int          m_fail_end;
    int          m_lock_end;
    int          m_chg_at;
    int          m_fails;
    int          m_lvl;
    logic [15:0] m_pw;
    logic        m_prev_enter;
    logic        m_prev_change;

    task automatic model_reset();
        m_cyc         = 0;
        m_succ_end    = 0;
        m_fail_end    = 0;
        m_lock_end    = 0;
        m_chg_at      = -1;
        m_fails       = 0;
        m_lvl         = 0;
        m_pw          = DEFAULT_PW;
        m_prev_enter  = 1'b0;
        m_prev_change = 1'b0;
    endtask

    task automatic model_step();
        logic er;
        logic cr;
        m_cyc++;
        er = enter_btn && !m_prev_enter;
        cr = change_btn && !m_prev_change;
        m_prev_enter  = enter_btn;
        m_prev_change = change_btn;
        if (m_cyc <= m_succ_end) begin
            if (cr) begin
                m_pw       = password_in;
                m_chg_at   = m_cyc;
                m_succ_end = m_cyc;
            end else if (er) begin
                m_succ_end = m_cyc;
            end
        end else if (m_cyc <= m_fail_end || m_cyc <= m_lock_end) begin
            // busy: every input is ignored
        end else if (er) begin
            if (password_in == m_pw) begin
                m_succ_end = m_cyc + int'(UNLOCK_CYCLES);
                m_fails    = 0;
                m_lvl      = 0;
            end else if (m_fails + 1 < int'(MAX_ATTEMPTS)) begin
                m_fails++;
                m_fail_end = m_cyc + int'(PULSE_CYCLES);
            end else begin
                m_fails    = 0;
                m_lock_end = m_cyc + int'(LOCK_CYCLES) * (2 ** m_lvl);
                if (m_lvl < int'(MAX_ESCALATE)) m_lvl++;
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else     model_step();
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) begin
            passes++;
        end else begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (model cycle %0d, t=%0t)",
                     name, act, exp, m_cyc, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b0) begin
                check("cyc_led_success", int'(led_success), int'(m_cyc < m_succ_end));
                check("cyc_led_fail", int'(led_fail), int'(m_cyc < m_fail_end));
                check("cyc_led_locked", int'(led_locked), int'(m_cyc < m_lock_end));
                check("cyc_pw_changed", int'(pw_changed), int'(m_chg_at == m_cyc));
                check("cyc_attempts_left", int'(attempts_left), int'(MAX_ATTEMPTS) - m_fails);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic sig(input int sel);
        case (sel)
            0:       return led_success;
            1:       return led_fail;
            default: return led_locked;
        endcase
    endfunction

    // Counts consecutive negedges (starting with the current one) with the LED high.
    task automatic count_high(input int sel, output int n);
        n = 0;
        while (sig(sel) && n < 400) begin
            n++;
            @(negedge clk);
        end
    endtask

    // Ends on the first negedge after the sampling posedge, when outputs reflect it.
    task automatic press(input logic [15:0] pw);
        @(negedge clk);
        password_in = pw;
        enter_btn   = 1'b1;
        @(negedge clk);
        enter_btn   = 1'b0;
    endtask

    task automatic fail_burst(input string tag);
        int n;
        press(16'hFFFF);
        check({tag, "_att_after_1"}, int'(attempts_left), 2);
        count_high(1, n);
        check({tag, "_fail_pulse_1"}, n, 4);
        press(16'hFFFF);
        check({tag, "_att_after_2"}, int'(attempts_left), 1);
        count_high(1, n);
        check({tag, "_fail_pulse_2"}, n, 4);
        press(16'hFFFF);
        check({tag, "_locked_on_3"}, int'(led_locked), 1);
        check({tag, "_no_fail_on_3"}, int'(led_fail), 0);
    endtask

    initial begin
        int n;
        rst         = 1'b1;
        enter_btn   = 1'b0;
        change_btn  = 1'b0;
        password_in = 16'h0000;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_led_success", int'(led_success), 0);
        check("reset_led_fail", int'(led_fail), 0);
        check("reset_led_locked", int'(led_locked), 0);
        check("reset_pw_changed", int'(pw_changed), 0);
        check("reset_attempts_left", int'(attempts_left), 3);

        // 1: correct password unlocks for exactly 16 cycles
        press(16'h1234);
        check("t1_attempts", int'(attempts_left), 3);
        count_high(0, n);
        check("t1_unlock_len", n, 16);
        repeat (3) @(negedge clk);

        // 2: three failures then a 20-cycle lockout
        fail_burst("t2");
        count_high(2, n);
        check("t2_lock_len", n, 20);
        check("t2_attempts_after", int'(attempts_left), 3);
        repeat (2) @(negedge clk);

        // 3: escalated 40-cycle lockout ignores the correct password
        fail_burst("t3");
        press(16'h1234);
        count_high(2, n);
        check("t3_lock_len_40", n + 2, 40);
        press(16'h1234);
        check("t3_unlock_after_lock", int'(led_success), 1);
        count_high(0, n);
        fail_burst("t3b");
        count_high(2, n);
        check("t3_lock_back_to_20", n, 20);

        // 4: password change and change/enter priority
        press(16'h1234);
        @(negedge clk);
        password_in = 16'hBEEF;
        change_btn  = 1'b1;
        @(negedge clk);
        change_btn  = 1'b0;
        check("t4_pw_changed_pulse", int'(pw_changed), 1);
        check("t4_relocked", int'(led_success), 0);
        @(negedge clk);
        check("t4_pw_changed_1cyc", int'(pw_changed), 0);
        press(16'h1234);
        check("t4_old_pw_fails", int'(led_fail), 1);
        count_high(1, n);
        press(16'hBEEF);
        check("t4_new_pw_unlocks", int'(led_success), 1);
        @(negedge clk);
        password_in = 16'h5A5A;
        enter_btn   = 1'b1;
        change_btn  = 1'b1;
        @(negedge clk);
        enter_btn   = 1'b0;
        change_btn  = 1'b0;
        check("t4_simul_change_wins", int'(pw_changed), 1);
        press(16'h5A5A);
        check("t4_5a5a_unlocks", int'(led_success), 1);
        press(16'h5A5A);
        check("t4_early_relock", int'(led_success), 0);

        // 5: held button counts once; held across lock exit does not refire
        @(negedge clk);
        password_in = 16'h0000;
        enter_btn   = 1'b1;
        repeat (50) @(negedge clk);
        check("t5_held_one_fail", int'(attempts_left), 2);
        enter_btn = 1'b0;
        press(16'h0000);
        check("t5_second_fail", int'(attempts_left), 1);
        count_high(1, n);
        @(negedge clk);
        enter_btn = 1'b1;
        @(negedge clk);
        check("t5_locked", int'(led_locked), 1);
        repeat (30) @(negedge clk);
        check("t5_lock_over", int'(led_locked), 0);
        check("t5_no_refire_fail", int'(led_fail), 0);
        check("t5_no_refire_att", int'(attempts_left), 3);
        enter_btn = 1'b0;
        @(negedge clk);

        // 6: async reset mid-lockout restores password and escalation
        fail_burst("t6");
        count_high(2, n);
        check("t6_lock_len_40", n, 40);
        fail_burst("t6b");
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("t6_async_locked", int'(led_locked), 0);
        check("t6_async_success", int'(led_success), 0);
        check("t6_async_fail", int'(led_fail), 0);
        check("t6_async_attempts", int'(attempts_left), 3);
        @(negedge clk);
        rst = 1'b0;
        fail_burst("t6c");
        count_high(2, n);
        check("t6_level_reset_20", n, 20);
        press(16'h1234);
        check("t6_default_pw_back", int'(led_success), 1);
        count_high(0, n);
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
